stream_demux_1x2: RTL and testbench

Buffered 1-to-2 demultiplexer: the sending-side counterpart of the 2:1 select mux. A single 32-bit valid/ready source stream is steered, word by word, to one of two consumer ports by a per-word select bit. Each consumer port has its own small FIFO, so a stalled consumer blocks only words addressed to it. It sits between the processor's result/fetch producers and the two downstream consumers that a 2:1 mux later merges back.

---
 rtl/stream_demux_1x2_if.sv | 32 +++
 rtl/stream_demux_1x2.sv | 104 ++++++++++
 tb/tb_stream_demux_1x2.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_1x2_if.sv
// Handshake bundle for the 1:2 stream demux: one source lane, two consumer lanes.
interface stream_demux_1x2_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic             in_select;
  logic [WIDTH-1:0] in_data;

  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic [CW-1:0]    a_count;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CW-1:0]    b_count;

  modport master (
    output in_valid, in_select, in_data, a_ready, b_ready,
    input  in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
  );

  modport slave (
    input  in_valid, in_select, in_data, a_ready, b_ready,
    output in_ready, a_valid, a_data, a_count, b_valid, b_data, b_count
  );
endinterface

// File: rtl/stream_demux_1x2.sv
// Buffered 1:2 stream demultiplexer: each word is steered by in_select into
// one of two independent circular FIFOs, so a stalled consumer blocks only its own port.
module stream_demux_1x2 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  stream_demux_1x2_if.slave      bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]    wptr_a, rptr_a, wptr_b, rptr_b;
  logic [CW-1:0]    count_a, count_b;

  logic full_a, full_b;
  logic valid_a, valid_b;
  logic accept;
  logic push_a, push_b, pop_a, pop_b;

  always_comb begin
    full_a  = (count_a == FULL_COUNT);
    full_b  = (count_b == FULL_COUNT);
    valid_a = (count_a != '0);
    valid_b = (count_b != '0);
  end

  // Readiness looks only at the selected FIFO's own fullness; consumer ready
  // is deliberately excluded so there is no full-bypass path.
  always_comb begin
    bus.in_ready = bus.in_select ? !full_b : !full_a;
  end

  always_comb begin
    accept = bus.in_valid && bus.in_ready;
    push_a = accept && !bus.in_select;
    push_b = accept &&  bus.in_select;
    pop_a  = valid_a && bus.a_ready;
    pop_b  = valid_b && bus.b_ready;
  end

  // Port a FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_a  <= '0;
      rptr_a  <= '0;
      count_a <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
      end
    end else begin
      if (push_a) begin
        mem_a[wptr_a] <= bus.in_data;
        wptr_a        <= wptr_a + 1'b1;
      end
      if (pop_a) begin
        rptr_a <= rptr_a + 1'b1;
      end
      if (push_a && !pop_a) begin
        count_a <= count_a + 1'b1;
      end else if (pop_a && !push_a) begin
        count_a <= count_a - 1'b1;
      end
    end
  end

  // Port b FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_b  <= '0;
      rptr_b  <= '0;
      count_b <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_b[i] <= '0;
      end
    end else begin
      if (push_b) begin
        mem_b[wptr_b] <= bus.in_data;
        wptr_b        <= wptr_b + 1'b1;
      end
      if (pop_b) begin
        rptr_b <= rptr_b + 1'b1;
      end
      if (push_b && !pop_b) begin
        count_b <= count_b + 1'b1;
      end else if (pop_b && !push_b) begin
        count_b <= count_b - 1'b1;
      end
    end
  end

  always_comb begin
    bus.a_valid = valid_a;
    bus.a_data  = mem_a[rptr_a];
    bus.a_count = count_a;
    bus.b_valid = valid_b;
    bus.b_data  = mem_b[rptr_b];
    bus.b_count = count_b;
  end
endmodule

// File: tb/tb_stream_demux_1x2.sv
// Directed self-checking bench for stream_demux_1x2 with hand-computed expectations.
module tb_stream_demux_1x2;
  logic clk;
  logic reset;
  int unsigned errors;
  int unsigned checks;

  stream_demux_1x2_if #(.WIDTH(32), .DEPTH(2)) bus ();

  stream_demux_1x2 #(.WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;

    // Reset held 2 cycles with traffic offered on both sides
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_select = 1'b0;
    bus.in_data   = 32'hDEADBEEF;
    bus.a_ready   = 1'b1;
    bus.b_ready   = 1'b1;
    tick();
    tick();
    check_eq("rst_a_valid", 64'(bus.a_valid), 64'd0);
    check_eq("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check_eq("rst_a_count", 64'(bus.a_count), 64'd0);
    check_eq("rst_b_count", 64'(bus.b_count), 64'd0);
    check_eq("rst_a_data",  64'(bus.a_data),  64'd0);
    check_eq("rst_b_data",  64'(bus.b_data),  64'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("rst_in_ready_sel0", 64'(bus.in_ready), 64'd1);
    bus.in_select = 1'b1;
    #1;
    check_eq("rst_in_ready_sel1", 64'(bus.in_ready), 64'd1);
    tick();
    check_eq("rst_no_accept_a", 64'(bus.a_count), 64'd0);
    check_eq("rst_no_accept_b", 64'(bus.b_count), 64'd0);

    // Steering
    bus.in_valid  = 1'b1;
    bus.in_select = 1'b0;
    bus.in_data   = 32'hA5A5A5A5;
    #1;
    check_eq("steer_ready0", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_select = 1'b1;
    bus.in_data   = 32'h12345678;
    check_eq("steer_a_valid", 64'(bus.a_valid), 64'd1);
    check_eq("steer_a_data",  64'(bus.a_data),  64'hA5A5A5A5);
    check_eq("steer_b_idle",  64'(bus.b_valid), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    check_eq("steer_a_gone",  64'(bus.a_valid), 64'd0);
    check_eq("steer_b_valid", 64'(bus.b_valid), 64'd1);
    check_eq("steer_b_data",  64'(bus.b_data),  64'h12345678);
    tick();
    check_eq("steer_b_gone",  64'(bus.b_valid), 64'd0);

    // Full / backpressure on port a
    bus.a_ready   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_select = 1'b0;
    bus.in_data   = 32'h1;
    tick();
    bus.in_data = 32'h2;
    tick();
    bus.in_data = 32'h3;
    #1;
    check_eq("full_count",    64'(bus.a_count),  64'd2);
    check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.a_ready = 1'b1;
    #1;
    check_eq("full_no_bypass", 64'(bus.in_ready), 64'd0);
    check_eq("full_head1",     64'(bus.a_data),   64'h1);
    tick();
    check_eq("full_head2",     64'(bus.a_data),   64'h2);
    check_eq("full_count1",    64'(bus.a_count),  64'd1);
    check_eq("full_ready_back", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check_eq("full_head3",  64'(bus.a_data),  64'h3);
    check_eq("full_count2", 64'(bus.a_count), 64'd1);
    tick();
    check_eq("full_drained", 64'(bus.a_valid), 64'd0);

    // Isolation: a full and stalled, b still flows
    bus.a_ready   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_select = 1'b0;
    bus.in_data   = 32'h11;
    tick();
    bus.in_data = 32'h22;
    tick();
    bus.in_select = 1'b1;
    bus.in_data   = 32'hB0B0B0B0;
    #1;
    check_eq("iso_ready_b", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check_eq("iso_b_valid", 64'(bus.b_valid), 64'd1);
    check_eq("iso_b_data",  64'(bus.b_data),  64'hB0B0B0B0);
    check_eq("iso_a_count", 64'(bus.a_count), 64'd2);
    check_eq("iso_a_head",  64'(bus.a_data),  64'h11);
    tick();
    check_eq("iso_b_gone",  64'(bus.b_valid), 64'd0);
    bus.a_ready = 1'b1;
    tick();
    check_eq("iso_a_head2", 64'(bus.a_data), 64'h22);
    tick();
    check_eq("iso_a_empty", 64'(bus.a_count), 64'd0);

    // Streaming with alternating select, wraps pointers several times
    for (int i = 0; i < 10; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_select = (i % 2) != 0;
      bus.in_data   = 32'(i);
      #1;
      check_eq($sformatf("stream_ready_%0d", i), 64'(bus.in_ready), 64'd1);
      tick();
      if ((i % 2) == 0) begin
        check_eq($sformatf("stream_a_data_%0d", i),  64'(bus.a_data),  64'(i));
        check_eq($sformatf("stream_a_count_%0d", i), 64'(bus.a_count), 64'd1);
        check_eq($sformatf("stream_b_count_%0d", i), 64'(bus.b_count), 64'd0);
      end else begin
        check_eq($sformatf("stream_b_data_%0d", i),  64'(bus.b_data),  64'(i));
        check_eq($sformatf("stream_b_count_%0d", i), 64'(bus.b_count), 64'd1);
        check_eq($sformatf("stream_a_count_%0d", i), 64'(bus.a_count), 64'd0);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    check_eq("stream_end_a", 64'(bus.a_count), 64'd0);
    check_eq("stream_end_b", 64'(bus.b_count), 64'd0);

    // Reset mid-stream with port b holding 2 words
    bus.b_ready   = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_select = 1'b1;
    bus.in_data   = 32'h77;
    tick();
    bus.in_data = 32'h88;
    tick();
    bus.in_valid = 1'b0;
    check_eq("mid_b_count2", 64'(bus.b_count), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_b_valid", 64'(bus.b_valid), 64'd0);
    check_eq("mid_b_count", 64'(bus.b_count), 64'd0);
    check_eq("mid_b_data",  64'(bus.b_data),  64'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hCAFEF00D;
    tick();
    bus.in_valid = 1'b0;
    check_eq("mid_new_data",  64'(bus.b_data),  64'hCAFEF00D);
    check_eq("mid_new_count", 64'(bus.b_count), 64'd1);
    bus.b_ready = 1'b1;
    tick();
    check_eq("mid_drained", 64'(bus.b_count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
